// File: rtl/gate_bist_ctrl.sv
// LFSR-driven BIST controller with MISR signature compaction for combinational gate models.
// Optional GATE_BIST_PIPE_EN: po_i is registered once before it reaches the MISR.
module gate_bist_ctrl #(
  parameter int                N_IN      = 23,
  parameter int                N_OUT     = 10,
  parameter int                PATTERNS  = 256,
  parameter logic [N_IN-1:0]   SEED      = 23'd1,
  parameter logic [N_IN-1:0]   TAPS      = 23'h420000,
  parameter logic [N_OUT-1:0]  MISR_TAPS = 10'h240
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [N_IN-1:0]                 pi_o,
  input  logic [N_OUT-1:0]                po_i,
  input  logic [N_OUT-1:0]                golden_i,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [N_OUT-1:0]                signature,
  output logic [$clog2(PATTERNS+1)-1:0]   pat_cnt
);

  localparam int CW = $clog2(PATTERNS+1);
  localparam logic [N_IN-1:0] SEED_LOAD = (SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : SEED;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(PATTERNS - 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(PATTERNS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [N_IN-1:0]  lfsr, lfsr_n, lfsr_step;
  logic [N_OUT-1:0] misr, misr_n, misr_step, po_src;
  logic [CW-1:0]    cnt_n, cnt_inc;

`ifdef GATE_BIST_PIPE_EN
  logic [N_OUT-1:0] po_q;
  logic             primed, primed_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_q   <= '0;
      primed <= 1'b0;
    end else begin
      po_q   <= po_i;
      primed <= primed_n;
    end
  end

  assign po_src = po_q;
`else
  assign po_src = po_i;
`endif

  assign lfsr_step = {lfsr[N_IN-2:0], ^(lfsr & TAPS)};
  assign misr_step = {misr[N_OUT-2:0], ^(misr & MISR_TAPS)} ^ po_src;
  assign cnt_inc   = (pat_cnt == CNT_MAX) ? pat_cnt : pat_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED_LOAD;
      misr    <= '0;
      pat_cnt <= '0;
    end else begin
      state   <= state_n;
      lfsr    <= lfsr_n;
      misr    <= misr_n;
      pat_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    misr_n  = misr;
    cnt_n   = pat_cnt;
`ifdef GATE_BIST_PIPE_EN
    primed_n = primed;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          lfsr_n  = SEED_LOAD;
          misr_n  = '0;
          cnt_n   = '0;
`ifdef GATE_BIST_PIPE_EN
          primed_n = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef GATE_BIST_PIPE_EN
        // The first cycle only fills po_q; the LFSR stops once it has supplied PATTERNS patterns.
        primed_n = 1'b1;
        if (!primed || pat_cnt != CNT_LAST) lfsr_n = lfsr_step;
        if (primed) begin
          misr_n = misr_step;
          cnt_n  = cnt_inc;
          if (pat_cnt == CNT_LAST) state_n = DONE;
        end
`else
        lfsr_n = lfsr_step;
        misr_n = misr_step;
        cnt_n  = cnt_inc;
        if (pat_cnt == CNT_LAST) state_n = DONE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign pi_o      = lfsr;
  assign signature = misr;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (misr == golden_i);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomised self-checking bench for gate_bist_ctrl against a behavioural signature model.
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-parameter instance driven by a behavioural gate model
  logic        start, busy, done, pass, tie0;
  logic [22:0] pi;
  logic [9:0]  po, golden, sig, key;
  logic [8:0]  cnt;

  function automatic logic [9:0] gm(input logic [22:0] p, input logic [9:0] k);
    return p[9:0] ^ (p[22:13] & p[12:3]) ^ k;
  endfunction

  assign po = tie0 ? 10'd0 : gm(pi, key);

  gate_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pi_o(pi), .po_i(po), .golden_i(golden),
    .busy(busy), .done(done), .pass(pass), .signature(sig), .pat_cnt(cnt)
  );

  // small instances for the hand-derived sequences
  logic       start_a, busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] pi_a, sig_a, pi_b, sig_b, golden_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;

  gate_bist_ctrl #(.N_IN(4), .N_OUT(4), .PATTERNS(15), .SEED(4'h1), .TAPS(4'h9), .MISR_TAPS(4'h9)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pi_o(pi_a), .po_i(4'h0), .golden_i(4'h0),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a)
  );

  gate_bist_ctrl #(.N_IN(4), .N_OUT(4), .PATTERNS(2), .SEED(4'h1), .TAPS(4'h9), .MISR_TAPS(4'h9)) dut_b (
    .clk(clk), .rst(rst), .start(start_a), .pi_o(pi_b), .po_i(4'h1), .golden_i(golden_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: apply 256 patterns from the x^23+x^18+1 sequence, compress with x^10+x^7+1.
  task automatic ref_run(input logic [9:0] k, input logic z,
                         output logic [9:0] s, output logic [22:0] last);
    logic [22:0] x;
    logic [9:0]  r;
    x = 23'd1;
    s = '0;
    for (int i = 0; i < 256; i++) begin
      r = z ? 10'd0 : gm(x, k);
      s = {s[8:0], s[9] ^ s[6]} ^ r;
      x = {x[21:0], x[22] ^ x[17]};
    end
    last = x;
  endtask

  task automatic do_run(input bit hold, output int cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("ld_sig", 32'(sig), 32'd0);
    check("ld_done", 32'(done), 32'd0);
    check("ld_cnt", 32'(cnt), 32'd0);
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int cyc, input logic [9:0] k, input logic z);
    logic [9:0]  es;
    logic [22:0] el;
    ref_run(k, z, es, el);
    check({tag, "_busy"}, 32'(cyc), 32'(256 + EXTRA));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_sig"}, 32'(sig), 32'(es));
    check({tag, "_cnt"}, 32'(cnt), 32'd256);
    check({tag, "_pi"}, 32'(pi), 32'(el));
    golden = es;
    #1 check({tag, "_pass1"}, 32'(pass), 32'd1);
    golden = es ^ 10'(1 + $urandom_range(0, 1022));
    #1 check({tag, "_pass0"}, 32'(pass), 32'd0);
  endtask

  initial begin
    int cyc, n;
    logic [3:0] seq [15];
    seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    rst = 1'b1; start = 1'b0; start_a = 1'b0; tie0 = 1'b0; key = '0; golden = '0; golden_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_pi", 32'(pi), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    key = 10'($urandom);
    do_run(1'b0, cyc);
    verify_run("run1", cyc, key, 1'b0);

    key = 10'($urandom);
    do_run(1'b1, cyc);
    verify_run("hold", cyc, key, 1'b0);

    // restart from DONE with the same key must reproduce the same result
    do_run(1'b0, cyc);
    verify_run("restart", cyc, key, 1'b0);

    tie0 = 1'b1;
    do_run(1'b0, cyc);
    verify_run("zero", cyc, key, 1'b1);
    golden = '0;
    #1 check("zero_pass", 32'(pass), 32'd1);
    tie0 = 1'b0;

    key = 10'($urandom);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (cnt != 9'd100 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("mid_reach", 32'(cnt), 32'd100);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_sig", 32'(sig), 32'd0);
    check("mid_pi", 32'(pi), 32'd1);
    check("mid_cnt", 32'(cnt), 32'd0);
    @(negedge clk) rst = 1'b0;
    do_run(1'b0, cyc);
    verify_run("post_rst", cyc, key, 1'b0);

    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 40) begin
      if (cyc < 15) check($sformatf("seq%0d", cyc), 32'(pi_a), 32'(seq[cyc]));
      cyc++;
      @(negedge clk);
    end
    check("a_busy", 32'(cyc), 32'(15 + EXTRA));
    check("a_done", 32'(done_a), 32'd1);
    check("a_pi", 32'(pi_a), 32'd1);
    check("a_cnt", 32'(cnt_a), 32'd15);

    check("b_done", 32'(done_b), 32'd1);
    check("b_sig", 32'(sig_b), 32'h2);
    check("b_cnt", 32'(cnt_b), 32'd2);
    golden_b = 4'h2;
    #1 check("b_pass1", 32'(pass_b), 32'd1);
    golden_b = 4'h3;
    #1 check("b_pass0", 32'(pass_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
